// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory arbiter: access sizes, sequencer
// states and the alignment rule used by the request error check.
package dmem_pkg;

   localparam logic [1:0] SIZE_B = 2'b00;
   localparam logic [1:0] SIZE_H = 2'b01;
   localparam logic [1:0] SIZE_W = 2'b10;
   localparam logic [1:0] SIZE_X = 2'b11;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      MERGE  = 2'd2,
      RESP   = 2'd3
   } dmem_state_t;

   // A halfword must sit on an even address, a word on a multiple of four.
   function automatic logic is_misaligned(input logic [1:0] size,
                                          input logic [1:0] addr_lo);
      logic bad;
      bad = 1'b0;
      case (size)
         SIZE_H:  bad = addr_lo[0];
         SIZE_W:  bad = (addr_lo != 2'b00);
         default: bad = 1'b0;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/dmem_lane_unit.sv
// Byte-lane datapath for the arbiter: pulls a byte/half out of a memory
// word for loads (with sign or zero extension) and splices store data
// into a previously read word for read-modify-write stores.
module dmem_lane_unit
   import dmem_pkg::*;
(
   input  logic [31:0] rd_word_i,     // word currently on the memory read bus
   input  logic [31:0] merge_word_i,  // word captured for a sub-word store
   input  logic [31:0] wdata_i,       // right-aligned store data
   input  logic [1:0]  lane_i,        // addr[1:0] of the access
   input  logic [1:0]  size_i,
   input  logic        signed_i,
   output logic [31:0] load_data_o,
   output logic [31:0] merged_o
);

   logic [7:0]  byte_v;
   logic [15:0] half_v;

   // Select the addressed lane and extend it to 32 bits for loads.
   always_comb begin
      byte_v      = 8'h00;
      half_v      = 16'h0000;
      load_data_o = rd_word_i;
      case (lane_i)
         2'd0:    byte_v = rd_word_i[7:0];
         2'd1:    byte_v = rd_word_i[15:8];
         2'd2:    byte_v = rd_word_i[23:16];
         default: byte_v = rd_word_i[31:24];
      endcase
      half_v = lane_i[1] ? rd_word_i[31:16] : rd_word_i[15:0];
      case (size_i)
         SIZE_B:  load_data_o = signed_i ? {{24{byte_v[7]}}, byte_v}
                                         : {24'h000000, byte_v};
         SIZE_H:  load_data_o = signed_i ? {{16{half_v[15]}}, half_v}
                                         : {16'h0000, half_v};
         default: load_data_o = rd_word_i;
      endcase
   end

   // Overwrite only the addressed byte or half of the captured word.
   always_comb begin
      merged_o = merge_word_i;
      case (size_i)
         SIZE_B: begin
            case (lane_i)
               2'd0:    merged_o[7:0]   = wdata_i[7:0];
               2'd1:    merged_o[15:8]  = wdata_i[7:0];
               2'd2:    merged_o[23:16] = wdata_i[7:0];
               default: merged_o[31:24] = wdata_i[7:0];
            endcase
         end
         SIZE_H: begin
            if (lane_i[1]) merged_o[31:16] = wdata_i[15:0];
            else           merged_o[15:0]  = wdata_i[15:0];
         end
         default: merged_o = wdata_i;
      endcase
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter and access sequencer in front of a
// single-port, word-wide data memory. Port 0 is the CPU load/store path,
// port 1 the debug/loader path. Sub-word stores are done as a read of the
// containing word followed by a write of the merged word.
//
// Handshake: a requester raises reqValid[p] with all fields stable and
// holds them until the cycle in which reqReady[p] is high; that cycle is
// the acceptance. reqReady is combinational, only ever high in IDLE, and
// only for the single winning port. Each accepted request produces exactly
// one rspValid[p] pulse carrying rspData/rspErr.
module dmem_arbiter
   import dmem_pkg::*;
#(
   parameter int unsigned MEM_BYTES = 1024
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [1:0]  reqValid,
   input  logic [1:0]  reqWrite,
   input  logic [63:0] reqAddr,     // {port1, port0}
   input  logic [63:0] reqWdata,    // {port1, port0}
   input  logic [3:0]  reqSize,     // {port1, port0}
   input  logic [1:0]  reqSigned,
   output logic [1:0]  reqReady,
   output logic [1:0]  rspValid,
   output logic [31:0] rspData,
   output logic        rspErr,
   output logic [31:0] memAddr,
   output logic [31:0] memWriteData,
   output logic        memWriteEnable,
   output logic        memReadEnable,
   input  logic [31:0] memReadData,
   output logic [1:0]  dbgState     // current sequencer state, for observation
);

   localparam logic [31:0] MEM_LIMIT = 32'(MEM_BYTES);

   dmem_state_t state_q, state_d;
   logic        last_grant_q, last_grant_d;
   logic        grant_q, grant_d;
   logic        write_q, write_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [1:0]  size_q, size_d;
   logic        signed_q, signed_d;
   logic        err_q, err_d;
   logic [31:0] rdata_q, rdata_d;
   logic [31:0] merge_q, merge_d;

   logic        winner;
   logic        sel_write;
   logic [31:0] sel_addr;
   logic [31:0] sel_wdata;
   logic [1:0]  sel_size;
   logic        sel_signed;
   logic        sel_err;
   logic [31:0] load_data;
   logic [31:0] merged_word;

   assign dbgState = state_q;

   dmem_lane_unit u_lane (
      .rd_word_i    (memReadData),
      .merge_word_i (merge_q),
      .wdata_i      (wdata_q),
      .lane_i       (addr_q[1:0]),
      .size_i       (size_q),
      .signed_i     (signed_q),
      .load_data_o  (load_data),
      .merged_o     (merged_word)
   );

   // Pick the winning port (alternate on contention) and flag bad requests.
   always_comb begin
      winner = 1'b0;
      case (reqValid)
         2'b01:   winner = 1'b0;
         2'b10:   winner = 1'b1;
         2'b11:   winner = ~last_grant_q;
         default: winner = 1'b0;
      endcase
      sel_write  = reqWrite[winner];
      sel_signed = reqSigned[winner];
      sel_addr   = winner ? reqAddr[63:32]  : reqAddr[31:0];
      sel_wdata  = winner ? reqWdata[63:32] : reqWdata[31:0];
      sel_size   = winner ? reqSize[3:2]    : reqSize[1:0];
      sel_err    = (sel_size == SIZE_X)
                || is_misaligned(sel_size, sel_addr[1:0])
                || (sel_addr >= MEM_LIMIT);
   end

   // Sequencer next state, register updates and all output strobes.
   always_comb begin
      state_d        = state_q;
      last_grant_d   = last_grant_q;
      grant_d        = grant_q;
      write_d        = write_q;
      addr_d         = addr_q;
      wdata_d        = wdata_q;
      size_d         = size_q;
      signed_d       = signed_q;
      err_d          = err_q;
      rdata_d        = rdata_q;
      merge_d        = merge_q;
      reqReady       = 2'b00;
      rspValid       = 2'b00;
      rspData        = 32'h0;
      rspErr         = 1'b0;
      memAddr        = 32'h0;
      memWriteData   = 32'h0;
      memWriteEnable = 1'b0;
      memReadEnable  = 1'b0;

      case (state_q)
         IDLE: begin
            if (reqValid != 2'b00) begin
               reqReady     = winner ? 2'b10 : 2'b01;
               last_grant_d = winner;
               grant_d      = winner;
               write_d      = sel_write;
               addr_d       = sel_addr;
               wdata_d      = sel_wdata;
               size_d       = sel_size;
               signed_d     = sel_signed;
               err_d        = sel_err;
               // Stores and errors answer with zero data.
               rdata_d      = 32'h0;
               // Bad requests skip the memory entirely.
               state_d      = sel_err ? RESP : ACCESS;
            end
         end

         ACCESS: begin
            memAddr = {addr_q[31:2], 2'b00};
            if (!write_q) begin
               memReadEnable = 1'b1;
               rdata_d       = load_data;
               state_d       = RESP;
            end else if (size_q == SIZE_W) begin
               memWriteEnable = 1'b1;
               memWriteData   = wdata_q;
               state_d        = RESP;
            end else begin
               // Sub-word store: fetch the containing word, write it next cycle.
               memReadEnable = 1'b1;
               merge_d       = memReadData;
               state_d       = MERGE;
            end
         end

         MERGE: begin
            memAddr        = {addr_q[31:2], 2'b00};
            memWriteEnable = 1'b1;
            memWriteData   = merged_word;
            state_d        = RESP;
         end

         RESP: begin
            rspValid = grant_q ? 2'b10 : 2'b01;
            rspData  = err_q ? 32'h0 : rdata_q;
            rspErr   = err_q;
            state_d  = IDLE;
         end

         default: state_d = IDLE;
      endcase
   end

   // State and request registers; reset abandons any in-flight request.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         last_grant_q <= 1'b1;
         grant_q      <= 1'b0;
         write_q      <= 1'b0;
         addr_q       <= 32'h0;
         wdata_q      <= 32'h0;
         size_q       <= SIZE_B;
         signed_q     <= 1'b0;
         err_q        <= 1'b0;
         rdata_q      <= 32'h0;
         merge_q      <= 32'h0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         grant_q      <= grant_d;
         write_q      <= write_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         size_q       <= size_d;
         signed_q     <= signed_d;
         err_q        <= err_d;
         rdata_q      <= rdata_d;
         merge_q      <= merge_d;
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed steps from the test plan
// followed by a randomized two-port phase scored against a byte-addressed
// reference memory.
module tb_dmem_arbiter;
   import dmem_pkg::*;

   // ---------------- clock / reset / DUT ----------------
   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  reqValid, reqWrite, reqSigned;
   logic [63:0] reqAddr, reqWdata;
   logic [3:0]  reqSize;
   logic [1:0]  reqReady, rspValid;
   logic [31:0] rspData;
   logic        rspErr;
   logic [31:0] memAddr, memWriteData, memReadData;
   logic        memWriteEnable, memReadEnable;
   logic [1:0]  dbgState;

   always #5 clk = ~clk;

   dmem_arbiter #(.MEM_BYTES(1024)) dut (
      .clk            (clk),
      .reset          (reset),
      .reqValid       (reqValid),
      .reqWrite       (reqWrite),
      .reqAddr        (reqAddr),
      .reqWdata       (reqWdata),
      .reqSize        (reqSize),
      .reqSigned      (reqSigned),
      .reqReady       (reqReady),
      .rspValid       (rspValid),
      .rspData        (rspData),
      .rspErr         (rspErr),
      .memAddr        (memAddr),
      .memWriteData   (memWriteData),
      .memWriteEnable (memWriteEnable),
      .memReadEnable  (memReadEnable),
      .memReadData    (memReadData),
      .dbgState       (dbgState)
   );

   // ---------------- memory attached to the DUT ----------------
   logic [31:0] mem [0:255];
   logic        mem_clr = 1'b0;
   logic        poke_en = 1'b0;
   logic [7:0]  poke_idx = 8'h0;
   logic [31:0] poke_val = 32'h0;

   assign memReadData = mem[memAddr[9:2]];

   always @(posedge clk) begin
      if (mem_clr) begin
         for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
      end else if (poke_en) begin
         mem[poke_idx] <= poke_val;
      end else if (memWriteEnable) begin
         mem[memAddr[9:2]] <= memWriteData;
      end
   end

   // ---------------- reference model and scoreboard ----------------
   logic [7:0]  ref_mem [0:1023];
   logic [33:0] exp_q[$];          // {port, err, data}
   int          tests_run = 0;
   int          tests_failed = 0;
   int          model_last;        // port granted most recently

   function automatic logic ref_err(input logic [31:0] a, input logic [1:0] sz);
      int n;
      if (sz == 2'b11) return 1'b1;
      n = 1 << sz;
      return ((a & 32'(n - 1)) != 32'h0) || (a >= 32'd1024);
   endfunction

   function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [1:0] sz,
                                            input logic sg);
      int n, base;
      logic [31:0] v;
      n = 1 << sz;
      base = int'(a[9:0]);
      v = 32'h0;
      for (int i = 0; i < n; i++) v[8*i +: 8] = ref_mem[base + i];
      if (sg && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
      return v;
   endfunction

   function automatic logic [31:0] ref_word(input logic [31:0] a);
      int b;
      b = int'({a[9:2], 2'b00});
      return {ref_mem[b+3], ref_mem[b+2], ref_mem[b+1], ref_mem[b]};
   endfunction

   task automatic ref_store(input logic [31:0] a, input logic [31:0] wd, input logic [1:0] sz);
      int n, base;
      n = 1 << sz;
      base = int'(a[9:0]);
      for (int i = 0; i < n; i++) ref_mem[base + i] = wd[8*i +: 8];
   endtask

   function automatic int ref_lat(input logic e, input logic w, input logic [1:0] sz);
      if (e) return 1;
      if (w && sz != SIZE_W) return 3;
      return 2;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic poke_word(input logic [31:0] a, input logic [31:0] v);
      poke_en  = 1'b1;
      poke_idx = a[9:2];
      poke_val = v;
      tick();
      poke_en  = 1'b0;
      ref_store({a[31:2], 2'b00}, v, SIZE_W);
   endtask

   task automatic set_port(input int p, input logic w, input logic [31:0] a,
                           input logic [31:0] wd, input logic [1:0] sz, input logic sg);
      reqWrite[p]          = w;
      reqSigned[p]         = sg;
      reqAddr[32*p +: 32]  = a;
      reqWdata[32*p +: 32] = wd;
      reqSize[2*p +: 2]    = sz;
   endtask

   // One request on one port from IDLE; checks handshake, latency, memory
   // strobes and response against the reference model.
   task automatic run_req(input int p, input logic w, input logic [31:0] a,
                          input logic [31:0] wd, input logic [1:0] sz, input logic sg,
                          input string tag, output logic [31:0] got, output logic got_err);
      logic        e;
      logic [31:0] d;
      int          lat, rd_n, wr_n, rsp_n, rsp_at, wr_at;
      logic [31:0] wr_data;
      e   = ref_err(a, sz);
      d   = (e || w) ? 32'h0 : ref_load(a, sz, sg);
      lat = ref_lat(e, w, sz);
      got = 32'h0;
      got_err = 1'b0;
      set_port(p, w, a, wd, sz, sg);
      reqValid = (p == 1) ? 2'b10 : 2'b01;
      #1;
      check({tag, "_ready"}, 32'(reqReady), (p == 1) ? 32'd2 : 32'd1);
      tick();
      reqValid = 2'b00;
      #1;
      rd_n = 0; wr_n = 0; rsp_n = 0; rsp_at = 0; wr_at = 0; wr_data = 32'h0;
      for (int c = 1; c <= 5; c++) begin
         if (memReadEnable || memWriteEnable)
            check({tag, "_memaddr"}, memAddr, {a[31:2], 2'b00});
         if (memReadEnable) rd_n++;
         if (memWriteEnable) begin
            wr_n++;
            wr_at = c;
            wr_data = memWriteData;
         end
         if (rspValid != 2'b00) begin
            rsp_n++;
            if (rsp_at == 0) begin
               rsp_at  = c;
               got     = rspData;
               got_err = rspErr;
               check({tag, "_rsp_port"}, 32'(rspValid), (p == 1) ? 32'd2 : 32'd1);
               check({tag, "_rsp_data"}, rspData, d);
               check({tag, "_rsp_err"}, 32'(rspErr), 32'(e));
            end
         end
         tick();
      end
      check({tag, "_latency"}, rsp_at, lat);
      check({tag, "_rsp_pulses"}, rsp_n, 1);
      check({tag, "_reads"}, rd_n, (!e && (!w || sz != SIZE_W)) ? 1 : 0);
      check({tag, "_writes"}, wr_n, (!e && w) ? 1 : 0);
      if (!e && w) begin
         ref_store(a, wd, sz);
         check({tag, "_write_cycle"}, wr_at, lat - 1);
         check({tag, "_write_data"}, wr_data, ref_word(a));
         check({tag, "_mem_word"}, mem[a[9:2]], ref_word(a));
      end
      model_last = p;
   endtask

   // ---------------- random phase state ----------------
   logic [1:0]  pv, pw, psg;
   logic [31:0] pa [2];
   logic [31:0] pd [2];
   logic [1:0]  psz [2];

   task automatic gen_req(input int p);
      int r;
      r      = $urandom_range(0, 15);
      psz[p] = 2'($urandom_range(0, 2));
      pw[p]  = 1'($urandom_range(0, 1));
      psg[p] = 1'($urandom_range(0, 1));
      pd[p]  = $urandom();
      pa[p]  = 32'($urandom_range(0, 63));
      if (r != 1) pa[p] = pa[p] & ~32'((1 << psz[p]) - 1);
      if (r == 0) psz[p] = 2'b11;
      if (r == 2) pa[p] = 32'd1024 + 32'($urandom_range(0, 2000));
      if (r == 3) pa[p] = 32'd1020;
   endtask

   // ---------------- stimulus ----------------
   logic [31:0] got;
   logic        got_err;
   logic [33:0] ent;
   int          grants[$];
   int          rdy_cnt[2];
   int          busy, winner;
   logic        e, w;

   initial begin
      reset = 1'b1;
      reqValid = 2'b00; reqWrite = 2'b00; reqSigned = 2'b00;
      reqAddr = 64'h0; reqWdata = 64'h0; reqSize = 4'h0;
      for (int i = 0; i < 1024; i++) ref_mem[i] = 8'h00;
      mem_clr = 1'b1;
      tick();
      mem_clr = 1'b0;
      // Reset values while reset is held.
      check("rst_ready", 32'(reqReady), 32'd0);
      check("rst_rspvalid", 32'(rspValid), 32'd0);
      check("rst_rspdata", rspData, 32'd0);
      check("rst_rsperr", 32'(rspErr), 32'd0);
      check("rst_memaddr", memAddr, 32'd0);
      check("rst_memwdata", memWriteData, 32'd0);
      check("rst_memwe", 32'(memWriteEnable), 32'd0);
      check("rst_memre", 32'(memReadEnable), 32'd0);
      check("rst_state", 32'(dbgState), 32'(IDLE));
      poke_word(32'h0, 32'h0000_0005);
      reset = 1'b0;
      model_last = 1;
      tick();
      check("idle_state", 32'(dbgState), 32'(IDLE));

      // Word load after reset.
      run_req(0, 1'b0, 32'h0, 32'h0, SIZE_W, 1'b0, "lw0", got, got_err);
      check("lw0_value", got, 32'h0000_0005);

      // Byte store into a known word, then signed / unsigned byte loads.
      poke_word(32'h4, 32'h1122_3344);
      run_req(0, 1'b1, 32'h6, 32'h0000_00AB, SIZE_B, 1'b0, "sb6", got, got_err);
      check("sb6_word", mem[1], 32'h11AB_3344);
      run_req(0, 1'b0, 32'h6, 32'h0, SIZE_B, 1'b1, "lb6", got, got_err);
      check("lb6_value", got, 32'hFFFF_FFAB);
      run_req(0, 1'b0, 32'h6, 32'h0, SIZE_B, 1'b0, "lbu6", got, got_err);
      check("lbu6_value", got, 32'h0000_00AB);

      // Halfword loads of a negative upper half.
      poke_word(32'h0, 32'h8000_1234);
      run_req(0, 1'b0, 32'h2, 32'h0, SIZE_H, 1'b1, "lh2", got, got_err);
      check("lh2_value", got, 32'hFFFF_8000);
      run_req(1, 1'b0, 32'h2, 32'h0, SIZE_H, 1'b0, "lhu2", got, got_err);
      check("lhu2_value", got, 32'h0000_8000);

      // Port 1 word store and half store at the top word of memory.
      run_req(1, 1'b1, 32'h3FC, 32'hDEAD_BEEF, SIZE_W, 1'b0, "sw3fc", got, got_err);
      run_req(1, 1'b1, 32'h3FE, 32'h0000_7777, SIZE_H, 1'b0, "sh3fe", got, got_err);
      check("sh3fe_word", mem[255], 32'h7777_BEEF);

      // Error requests: no memory strobes, error at T+1 with zero data.
      run_req(0, 1'b0, 32'h2, 32'h0, SIZE_W, 1'b0, "err_lw2", got, got_err);
      check("err_lw2_flag", 32'(got_err), 32'd1);
      run_req(0, 1'b1, 32'h1, 32'h1234, SIZE_H, 1'b0, "err_sh1", got, got_err);
      check("err_sh1_flag", 32'(got_err), 32'd1);
      run_req(1, 1'b0, 32'h400, 32'h0, SIZE_W, 1'b0, "err_lw400", got, got_err);
      check("err_lw400_flag", 32'(got_err), 32'd1);
      run_req(0, 1'b0, 32'h0, 32'h0, 2'b11, 1'b0, "err_size3", got, got_err);
      check("err_size3_flag", 32'(got_err), 32'd1);

      // Reset while a halfword store sits in MERGE.
      poke_word(32'h10, 32'hCAFE_BABE);
      set_port(0, 1'b1, 32'h12, 32'h0000_1234, SIZE_H, 1'b0);
      reqValid = 2'b01;
      #1;
      check("mrst_ready", 32'(reqReady), 32'd1);
      tick();
      reqValid = 2'b00;
      check("mrst_in_access", 32'(dbgState), 32'(ACCESS));
      tick();
      check("mrst_in_merge", 32'(dbgState), 32'(MERGE));
      check("mrst_we_before", 32'(memWriteEnable), 32'd1);
      reset = 1'b1;
      #1;
      check("mrst_we_drop", 32'(memWriteEnable), 32'd0);
      check("mrst_re_drop", 32'(memReadEnable), 32'd0);
      check("mrst_state", 32'(dbgState), 32'(IDLE));
      check("mrst_rsp", 32'(rspValid), 32'd0);
      tick();
      tick();
      reset = 1'b0;
      model_last = 1;
      for (int c = 0; c < 4; c++) begin
         check("mrst_no_rsp", 32'(rspValid), 32'd0);
         tick();
      end
      check("mrst_word_kept", mem[4], 32'hCAFE_BABE);

      // Fairness: both ports request continuously straight out of reset.
      poke_word(32'h20, 32'hA0A0_A0A0);
      poke_word(32'h24, 32'h0B0B_0B0B);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      model_last = 1;
      set_port(0, 1'b0, 32'h20, 32'h0, SIZE_W, 1'b0);
      set_port(1, 1'b0, 32'h24, 32'h0, SIZE_W, 1'b0);
      reqValid = 2'b11;
      rdy_cnt[0] = 0;
      rdy_cnt[1] = 0;
      #1;
      for (int c = 0; c < 12; c++) begin
         check("fair_onehot", 32'(reqReady != 2'b11), 32'd1);
         for (int p = 0; p < 2; p++) begin
            if (reqReady[p]) begin
               grants.push_back(p);
               rdy_cnt[p]++;
               exp_q.push_back({p[0], 1'b0, ref_load((p == 1) ? 32'h24 : 32'h20, SIZE_W, 1'b0)});
            end
         end
         if (rspValid != 2'b00) begin
            if (exp_q.size() == 0) begin
               check("fair_unexpected_rsp", 32'(rspValid), 32'd0);
            end else begin
               ent = exp_q.pop_front();
               check("fair_rsp_port", 32'(rspValid), ent[33] ? 32'd2 : 32'd1);
               check("fair_rsp_data", rspData, ent[31:0]);
            end
         end
         tick();
      end
      reqValid = 2'b00;
      check("fair_grant_count", grants.size(), 4);
      for (int i = 0; i < 4 && i < grants.size(); i++)
         check("fair_grant_order", grants[i], i % 2);
      check("fair_ready_pulses_p0", rdy_cnt[0], 2);
      check("fair_ready_pulses_p1", rdy_cnt[1], 2);
      check("fair_drained", exp_q.size(), 0);
      exp_q.delete();
      model_last = 1;
      tick();

      // Randomized two-port traffic against the reference model.
      pv = 2'b00; pw = 2'b00; psg = 2'b00;
      for (int p = 0; p < 2; p++) begin
         pa[p] = 32'h0; pd[p] = 32'h0; psz[p] = SIZE_W;
      end
      busy = 0;
      for (int cyc = 0; cyc < 600; cyc++) begin
         for (int p = 0; p < 2; p++) begin
            if (!pv[p] && cyc < 560 && $urandom_range(0, 3) == 0) begin
               gen_req(p);
               pv[p] = 1'b1;
            end
            set_port(p, pw[p], pa[p], pd[p], psz[p], psg[p]);
         end
         reqValid = pv;
         #1;
         winner = (pv == 2'b11) ? 1 - model_last : (pv[1] ? 1 : 0);
         if (busy == 0 && pv != 2'b00)
            check("rnd_ready", 32'(reqReady), (winner == 1) ? 32'd2 : 32'd1);
         else
            check("rnd_ready_idle", 32'(reqReady), 32'd0);
         if (busy == 1) begin
            if (exp_q.size() == 0) begin
               check("rnd_queue_empty", 32'd1, 32'd0);
            end else begin
               ent = exp_q.pop_front();
               check("rnd_rsp_port", 32'(rspValid), ent[33] ? 32'd2 : 32'd1);
               check("rnd_rsp_data", rspData, ent[31:0]);
               check("rnd_rsp_err", 32'(rspErr), 32'(ent[32]));
            end
         end else begin
            check("rnd_no_rsp", 32'(rspValid), 32'd0);
         end
         if (busy > 0) begin
            busy--;
         end else if (pv != 2'b00) begin
            e = ref_err(pa[winner], psz[winner]);
            w = pw[winner];
            exp_q.push_back({winner[0], e,
                             (e || w) ? 32'h0 : ref_load(pa[winner], psz[winner], psg[winner])});
            if (!e && w) ref_store(pa[winner], pd[winner], psz[winner]);
            busy = ref_lat(e, w, psz[winner]);
            model_last = winner;
            pv[winner] = 1'b0;
         end
         tick();
      end
      reqValid = 2'b00;
      check("rnd_drained", exp_q.size(), 0);
      check("rnd_all_accepted", 32'(pv), 32'd0);
      for (int i = 0; i < 256; i++)
         check($sformatf("mem_final_%0d", i), mem[i], ref_word(32'(i * 4)));

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   // Hard stop in case the run never reaches its summary.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, %0d failed so far", tests_failed);
      $fatal(1, "watchdog expired");
   end

endmodule
